// File: rtl/bit_serial_alu_seq.sv
// Bit-serial ALU sequencer: drives one external 1-bit ALU slice LSB first,
// keeps the ripple carry between bits, runs a second pass for set-less-than,
// and publishes a parallel result with zero/overflow/carry/illegal flags.
module bit_serial_alu_seq #(
  parameter int WIDTH = 8,
  parameter int IDXW  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alu_ctl,
  output logic             s_in1,
  output logic             s_in2,
  output logic             s_carry_in,
  output logic             s_ainvert,
  output logic             s_binvert,
  output logic             s_less,
  output logic [1:0]       s_op,
  input  logic             s_result,
  input  logic             s_carry_out,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             carry_out,
  output logic             illegal
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_SLT  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic [3:0] CTL_AND = 4'b0000;
  localparam logic [3:0] CTL_OR  = 4'b0001;
  localparam logic [3:0] CTL_ADD = 4'b0010;
  localparam logic [3:0] CTL_SUB = 4'b0110;
  localparam logic [3:0] CTL_SLT = 4'b0111;
  localparam logic [3:0] CTL_NOR = 4'b1100;

  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(WIDTH - 1);

  // Control / working state
  logic [1:0]       state_q, state_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [3:0]       ctl_q, ctl_d;
  logic             carry_q, carry_d;
  logic             set_q, set_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             cf_q, cf_d;
  logic             ovf_q, ovf_d;
  logic             ill_q, ill_d;

  // Published outputs, updated once per operation
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             ovf_out_q, ovf_out_d;
  logic             cout_q, cout_d;
  logic             illegal_q, illegal_d;
  logic             done_q, done_d;

  logic ctl_legal;
  logic is_slt;

  assign is_slt = (ctl_q == CTL_SLT);

  // Classify the incoming control code; only consulted when a start is taken.
  always_comb begin
    case (alu_ctl)
      CTL_AND, CTL_OR, CTL_ADD, CTL_SUB, CTL_SLT, CTL_NOR: ctl_legal = 1'b1;
      default:                                            ctl_legal = 1'b0;
    endcase
  end

  // Drive the slice for the bit currently selected by idx_q; quiet outside a pass.
  always_comb begin
    // NOTE: every output gets a value before any branch so no latch is inferred.
    s_in1      = 1'b0;
    s_in2      = 1'b0;
    s_carry_in = 1'b0;
    s_ainvert  = 1'b0;
    s_binvert  = 1'b0;
    s_less     = 1'b0;
    s_op       = 2'b00;
    if (state_q == ST_CALC || state_q == ST_SLT) begin
      s_in1     = a_q[idx_q];
      s_in2     = b_q[idx_q];
      s_ainvert = ctl_q[3];
      s_binvert = ctl_q[2];
      if (state_q == ST_CALC) begin
        // SLT's first pass is a plain subtract so the sign/overflow can be observed.
        s_op       = is_slt ? 2'b10 : ctl_q[1:0];
        s_carry_in = (idx_q == '0) ? ctl_q[2] : carry_q;
      end else begin
        s_op   = 2'b11;
        s_less = (idx_q == '0) ? set_q : 1'b0;
      end
    end
  end

  // Sequencer next-state: accept, step through the bits, publish on DONE.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    a_d       = a_q;
    b_d       = b_q;
    ctl_d     = ctl_q;
    carry_d   = carry_q;
    set_d     = set_q;
    res_d     = res_q;
    cf_d      = cf_q;
    ovf_d     = ovf_q;
    ill_d     = ill_q;
    result_d  = result_q;
    zero_d    = zero_q;
    ovf_out_d = ovf_out_q;
    cout_d    = cout_q;
    illegal_d = illegal_q;
    done_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // A start coinciding with the done pulse is not taken.
        if (start && !done_q) begin
          a_d     = a;
          b_d     = b;
          ctl_d   = alu_ctl;
          idx_d   = '0;
          carry_d = 1'b0;
          set_d   = 1'b0;
          res_d   = '0;
          cf_d    = 1'b0;
          ovf_d   = 1'b0;
          ill_d   = ~ctl_legal;
          state_d = ctl_legal ? ST_CALC : ST_DONE;
        end
      end

      ST_CALC: begin
        res_d[idx_q] = s_result;
        carry_d      = s_carry_out;
        if (idx_q == IDX_LAST) begin
          // Only the subtract/add family (ctl[1] set) reports arithmetic flags.
          cf_d  = ctl_q[1] & s_carry_out;
          ovf_d = ctl_q[1] & (s_carry_in ^ s_carry_out);
          if (is_slt) begin
            // Sign of the difference corrected by overflow gives the true signed compare.
            set_d   = s_result ^ s_carry_in ^ s_carry_out;
            idx_d   = '0;
            state_d = ST_SLT;
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          idx_d = idx_q + IDXW'(1);
        end
      end

      ST_SLT: begin
        res_d[idx_q] = s_result;
        if (idx_q == IDX_LAST) begin
          cf_d    = 1'b0;
          ovf_d   = 1'b0;
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + IDXW'(1);
        end
      end

      ST_DONE: begin
        result_d  = res_q;
        zero_d    = (res_q == '0);
        ovf_out_d = ovf_q;
        cout_d    = cf_q;
        illegal_d = ill_q;
        done_d    = 1'b1;
        state_d   = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with synchronous reset; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      ctl_q     <= '0;
      carry_q   <= 1'b0;
      set_q     <= 1'b0;
      res_q     <= '0;
      cf_q      <= 1'b0;
      ovf_q     <= 1'b0;
      ill_q     <= 1'b0;
      result_q  <= '0;
      zero_q    <= 1'b0;
      ovf_out_q <= 1'b0;
      cout_q    <= 1'b0;
      illegal_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      a_q       <= a_d;
      b_q       <= b_d;
      ctl_q     <= ctl_d;
      carry_q   <= carry_d;
      set_q     <= set_d;
      res_q     <= res_d;
      cf_q      <= cf_d;
      ovf_q     <= ovf_d;
      ill_q     <= ill_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      ovf_out_q <= ovf_out_d;
      cout_q    <= cout_d;
      illegal_q <= illegal_d;
      done_q    <= done_d;
    end
  end

  assign busy      = (state_q == ST_CALC) || (state_q == ST_SLT);
  assign done      = done_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign overflow  = ovf_out_q;
  assign carry_out = cout_q;
  assign illegal   = illegal_q;

endmodule
